// File: rtl/sti_load_ctrl.sv
// Command-FIFO front end for the STI_DAC datapath: queues pattern words and sequences
// one load/serialise handshake per word, tracking frame word counts and start timeouts.
module sti_load_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_cfg,
  input  logic        cmd_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        busy,
  output logic [7:0]  word_count,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitStart, StWaitDone, StFinish} state_e;

  state_e state_q, state_d;

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          push, pop;
  logic [32:0]   head;

  logic [TW-1:0] timer_q;
  logic          timeout_hit;
  logic          frame_done_q;

  assign push = cmd_valid & ~full_q;
  assign pop  = (state_q == StIdle) & ~empty_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_last, cmd_cfg, cmd_data};
    end
  end

  // Full/empty are registered so cmd_ready never depends combinationally on cmd_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign timeout_hit = (state_q == StWaitStart) && !so_valid &&
                       (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (!empty_q) state_d = StLoad;
      StLoad:      state_d = StWaitStart;
      StWaitStart: begin
        if (so_valid) begin
          state_d = StWaitDone;
        end else if (timeout_hit) begin
          state_d = pi_end ? StFinish : StIdle;
        end
      end
      StWaitDone:  if (!so_valid) state_d = pi_end ? StFinish : StIdle;
      StFinish:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    load      = (state_q == StLoad);
    done      = (state_q == StFinish);
    busy      = (state_q != StIdle) || !empty_q;
    cmd_ready = ~full_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pi_data      <= '0;
      pi_length    <= '0;
      pi_fill      <= 1'b0;
      pi_msb       <= 1'b0;
      pi_low       <= 1'b0;
      pi_end       <= 1'b0;
      word_count   <= '0;
      timeout_err  <= 1'b0;
      timer_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (pop) begin
        pi_data   <= head[15:0];
        pi_length <= head[29:28];
        pi_fill   <= head[24];
        pi_msb    <= head[20];
        pi_low    <= head[16];
        pi_end    <= head[32];
        // The count of a finished frame stays visible until the next frame starts.
        if (frame_done_q) begin
          word_count   <= '0;
          frame_done_q <= 1'b0;
        end
      end
      if (state_q == StLoad) begin
        timer_q <= '0;
      end else if (state_q == StWaitStart) begin
        timer_q <= timer_q + TW'(1);
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if ((state_q == StWaitDone) && !so_valid && (word_count != 8'hFF)) begin
        word_count <= word_count + 8'd1;
      end
      if (state_q == StFinish) begin
        pi_end       <= 1'b0;
        frame_done_q <= 1'b1;
      end
    end
  end

endmodule
